round_sequencer: RTL and testbench

//  Game controller that sequences check_move across a Bop-it game: picks a

---
 rtl/round_sequencer_if.sv | 42 ++++
 rtl/round_sequencer.sv | 205 ++++++++++++++++++++
 tb/tb_round_sequencer.sv | 282 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/round_sequencer_if.sv
// round_sequencer_if
//  Bundles the sequencer's game-side signals so the controller and whatever
//  sits around it (check_move, debouncers, display logic, a bench) share one
//  port list.
//  master : the round sequencer (drives chk_start, move, play_freq, status)
//  slave  : the environment (drives go and the check_move verdict lines)
//  Signals:
//   go, chk_ready, chk_correct, chk_halfway   environment -> sequencer
//   chk_start, move[12:0], play_freq[28:0], move_show,
//   score[SCORE_W-1:0], lives[1:0], busy, game_over,
//   round_pass, round_fail, dbg_state[2:0]    sequencer -> environment
interface round_sequencer_if #(
  parameter int SCORE_W = 10
);
  logic               go;
  logic               chk_ready;
  logic               chk_correct;
  logic               chk_halfway;
  logic               chk_start;
  logic [12:0]        move;
  logic [28:0]        play_freq;
  logic               move_show;
  logic [SCORE_W-1:0] score;
  logic [1:0]         lives;
  logic               busy;
  logic               game_over;
  logic               round_pass;
  logic               round_fail;
  logic [2:0]         dbg_state;

  modport master (
    input  go, chk_ready, chk_correct, chk_halfway,
    output chk_start, move, play_freq, move_show, score, lives,
           busy, game_over, round_pass, round_fail, dbg_state
  );

  modport slave (
    output go, chk_ready, chk_correct, chk_halfway,
    input  chk_start, move, play_freq, move_show, score, lives,
           busy, game_over, round_pass, round_fail, dbg_state
  );
endinterface

// File: rtl/round_sequencer.sv
// round_sequencer
//  Bop-it game controller. Picks a pseudo-random move, kicks check_move with
//  a one-cycle start pulse, waits for its verdict, then updates score/lives
//  and shortens the move window after every correct move.
//  Ports:
//   clk   system clock
//   rst   asynchronous, active-high reset
//   bus   round_sequencer_if.master (go / check_move handshake in,
//         move, play_freq, score, lives and status flags out)
//  Handshake with check_move: chk_start is a single-cycle request; the
//  verdict is accepted on the first WAIT cycle where chk_ready=1 (chk_ready
//  acts as "valid", the sequencer is always ready in WAIT), and chk_correct
//  is captured on that same edge. A chk_ready that was already high when
//  the request went out is treated as stale and ignored until it drops.
//  All outputs are registered; dbg_state exposes the FSM state.
module round_sequencer #(
  parameter logic [28:0] FREQ_INIT = 29'd200_000_000,
  parameter logic [28:0] FREQ_STEP = 29'd5_000_000,
  parameter logic [28:0] FREQ_MIN  = 29'd50_000_000,
  parameter logic [1:0]  LIVES     = 2'd3,
  parameter logic [23:0] GAP_CYC   = 24'd25_000_000,
  parameter int          SCORE_W   = 10,
  parameter logic [15:0] LFSR_SEED = 16'hACE1
) (
  input  logic              clk,
  input  logic              rst,
  round_sequencer_if.master bus
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_ISSUE = 3'd1,
    S_WAIT  = 3'd2,
    S_JUDGE = 3'd3,
    S_GAP   = 3'd4,
    S_OVER  = 3'd5
  } state_t;

  localparam logic [15:0] LFSR_TAPS = 16'hB400;
  // Widened by one bit so FREQ_MIN+FREQ_STEP cannot wrap.
  localparam logic [29:0] FLOOR_THR = {1'b0, FREQ_MIN} + {1'b0, FREQ_STEP};

  state_t             state_q, state_d;
  logic [15:0]        lfsr_q, lfsr_d;
  logic [12:0]        move_q, move_d;
  logic [28:0]        freq_q, freq_d;
  logic [SCORE_W-1:0] score_q, score_d;
  logic [1:0]         lives_q, lives_d;
  logic [23:0]        gap_q, gap_d;
  logic               chk_start_q, chk_start_d;
  logic               move_show_q, move_show_d;
  logic               busy_q, busy_d;
  logic               game_over_q, game_over_d;
  logic               pass_q, pass_d;
  logic               fail_q, fail_d;
  logic               stale_q, stale_d;

  logic [3:0]         lfsr_idx;
  logic [12:0]        next_move;
  logic               issue_now;
  logic               reinit_now;

  // Fold the 4-bit LFSR slice onto 13 moves.
  always_comb begin
    lfsr_idx = lfsr_q[3:0];
    if (lfsr_idx >= 4'd13) lfsr_idx = lfsr_idx - 4'd13;
    next_move = 13'd1 << lfsr_idx;
  end

  always_comb begin
    state_d     = state_q;
    lfsr_d      = {1'b0, lfsr_q[15:1]} ^ (lfsr_q[0] ? LFSR_TAPS : 16'h0000);
    move_d      = move_q;
    freq_d      = freq_q;
    score_d     = score_q;
    lives_d     = lives_q;
    gap_d       = gap_q;
    chk_start_d = 1'b0;
    move_show_d = move_show_q;
    busy_d      = busy_q;
    game_over_d = game_over_q;
    pass_d      = 1'b0;
    fail_d      = 1'b0;
    stale_d     = stale_q;
    issue_now   = 1'b0;
    reinit_now  = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (bus.go) begin
          reinit_now = 1'b1;
          issue_now  = 1'b1;
        end
      end
      S_ISSUE: begin
        state_d = S_WAIT;
        // Remember a ready that was already up while the request went out.
        stale_d = bus.chk_ready;
      end
      S_WAIT: begin
        if (bus.chk_halfway) move_show_d = 1'b0;
        if (bus.chk_ready && !stale_q) begin
          state_d     = S_JUDGE;
          move_show_d = 1'b0;
          if (bus.chk_correct) begin
            pass_d = 1'b1;
            if (score_q != {SCORE_W{1'b1}}) score_d = score_q + 1'b1;
            if ({1'b0, freq_q} <= FLOOR_THR) freq_d = FREQ_MIN;
            else                             freq_d = freq_q - FREQ_STEP;
          end else begin
            fail_d  = 1'b1;
            lives_d = lives_q - 2'd1;
          end
        end else begin
          stale_d = stale_q & bus.chk_ready;
        end
      end
      S_JUDGE: begin
        if (lives_q == 2'd0) begin
          state_d     = S_OVER;
          game_over_d = 1'b1;
          busy_d      = 1'b0;
        end else begin
          state_d = S_GAP;
          gap_d   = 24'd0;
        end
      end
      S_GAP: begin
        if (gap_q >= GAP_CYC - 24'd1) issue_now = 1'b1;
        else                          gap_d = gap_q + 24'd1;
      end
      S_OVER: begin
        if (bus.go) begin
          reinit_now = 1'b1;
          issue_now  = 1'b1;
        end
      end
      default: begin
        state_d = S_IDLE;
        busy_d  = 1'b0;
      end
    endcase

    if (reinit_now) begin
      score_d     = '0;
      lives_d     = LIVES;
      freq_d      = FREQ_INIT;
      game_over_d = 1'b0;
    end
    if (issue_now) begin
      state_d     = S_ISSUE;
      chk_start_d = 1'b1;
      move_d      = next_move;
      move_show_d = 1'b1;
      busy_d      = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= S_IDLE;
      lfsr_q      <= LFSR_SEED;
      move_q      <= 13'd0;
      freq_q      <= FREQ_INIT;
      score_q     <= '0;
      lives_q     <= LIVES;
      gap_q       <= 24'd0;
      chk_start_q <= 1'b0;
      move_show_q <= 1'b0;
      busy_q      <= 1'b0;
      game_over_q <= 1'b0;
      pass_q      <= 1'b0;
      fail_q      <= 1'b0;
      stale_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      lfsr_q      <= lfsr_d;
      move_q      <= move_d;
      freq_q      <= freq_d;
      score_q     <= score_d;
      lives_q     <= lives_d;
      gap_q       <= gap_d;
      chk_start_q <= chk_start_d;
      move_show_q <= move_show_d;
      busy_q      <= busy_d;
      game_over_q <= game_over_d;
      pass_q      <= pass_d;
      fail_q      <= fail_d;
      stale_q     <= stale_d;
    end
  end

  assign bus.chk_start  = chk_start_q;
  assign bus.move       = move_q;
  assign bus.play_freq  = freq_q;
  assign bus.move_show  = move_show_q;
  assign bus.score      = score_q;
  assign bus.lives      = lives_q;
  assign bus.busy       = busy_q;
  assign bus.game_over  = game_over_q;
  assign bus.round_pass = pass_q;
  assign bus.round_fail = fail_q;
  assign bus.dbg_state  = state_q;

endmodule

// File: tb/tb_round_sequencer.sv
// tb_round_sequencer
//  Bench for round_sequencer with a small game configuration
//  (window 100, step 10, floor 50, 3-cycle gap). A timeline model tracks
//  when starts and verdict pulses are due and what score/lives/window must
//  read, and is compared against the DUT on every falling edge. Directed
//  scenarios add hand-computed literal checks.
module tb_round_sequencer;
  localparam logic [28:0] P_INIT  = 29'd100;
  localparam logic [28:0] P_STEP  = 29'd10;
  localparam logic [28:0] P_MIN   = 29'd50;
  localparam logic [23:0] P_GAP   = 24'd3;
  localparam int          P_SW    = 10;
  localparam logic [15:0] P_SEED  = 16'hACE1;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  round_sequencer_if #(.SCORE_W(P_SW)) bus ();

  round_sequencer #(
    .FREQ_INIT(P_INIT), .FREQ_STEP(P_STEP), .FREQ_MIN(P_MIN),
    .LIVES(2'd3), .GAP_CYC(P_GAP), .SCORE_W(P_SW), .LFSR_SEED(P_SEED)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  int total = 0;
  int bad   = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h at t=%0t", name, act, exp, $time);
    end
  endtask

  // ---------------- model ----------------
  localparam int M_IDLE = 0, M_START = 1, M_ISSUE = 2, M_WAIT = 3, M_BUSY = 4, M_OVER = 5;

  logic [15:0] m_lfsr, m_lfsr_prev;
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_lfsr      <= P_SEED;
      m_lfsr_prev <= P_SEED;
    end else begin
      m_lfsr_prev <= m_lfsr;
      m_lfsr      <= (m_lfsr >> 1) ^ (m_lfsr[0] ? 16'hB400 : 16'h0000);
    end
  end

  function automatic logic [12:0] exp_move(input logic [15:0] l);
    int i;
    i = int'(l[3:0]);
    if (i >= 13) i = i - 13;
    return 13'd1 << i;
  endfunction

  int          m_phase, m_next_start, m_pulse_at;
  int          m_score, m_lives, m_freq;
  logic        m_verdict, m_stale, m_over, m_over_pend, m_busy, m_show, m_show_off;
  logic [12:0] m_move, seen;

  task automatic model_reset();
    m_phase = M_IDLE; m_next_start = -1; m_pulse_at = -1;
    m_score = 0; m_lives = 3; m_freq = int'(P_INIT);
    m_verdict = 0; m_stale = 0; m_over = 0; m_over_pend = 0;
    m_busy = 0; m_show = 0; m_show_off = 0; m_move = '0;
  endtask

  initial begin
    model_reset();
    seen = '0;
  end

  always @(negedge clk) begin
    if (rst) begin
      model_reset();
    end else begin
      if (m_show_off) begin m_show = 0; m_show_off = 0; end
      if (m_over_pend) begin
        m_over_pend = 0; m_phase = M_OVER; m_over = 1; m_busy = 0;
      end
      chk("chk_start", {31'b0, bus.chk_start}, {31'b0, cyc == m_next_start});
      if (cyc == m_next_start) begin
        if (m_phase == M_START) begin
          m_score = 0; m_lives = 3; m_freq = int'(P_INIT); m_over = 0;
        end
        m_move = exp_move(m_lfsr_prev);
        seen   = seen | bus.move;
        m_show = 1; m_busy = 1; m_phase = M_ISSUE; m_next_start = -1;
      end
      chk("round_pass", {31'b0, bus.round_pass}, {31'b0, (cyc == m_pulse_at) && m_verdict});
      chk("round_fail", {31'b0, bus.round_fail}, {31'b0, (cyc == m_pulse_at) && !m_verdict});
      if (cyc == m_pulse_at) begin
        if (m_verdict) begin
          if (m_score < (1 << P_SW) - 1) m_score = m_score + 1;
          m_freq = (m_freq - int'(P_STEP) < int'(P_MIN)) ? int'(P_MIN) : m_freq - int'(P_STEP);
        end else begin
          m_lives = m_lives - 1;
        end
        if (m_lives == 0) m_over_pend = 1;
        else              m_next_start = cyc + int'(P_GAP) + 1;
        m_show = 0; m_pulse_at = -1;
      end
      chk("move",      {19'b0, bus.move},            {19'b0, m_move});
      chk("move_show", {31'b0, bus.move_show},       {31'b0, m_show});
      chk("score",     {22'b0, bus.score},           m_score);
      chk("lives",     {30'b0, bus.lives},           m_lives);
      chk("play_freq", {3'b0, bus.play_freq},        m_freq);
      chk("busy",      {31'b0, bus.busy},            {31'b0, m_busy});
      chk("game_over", {31'b0, bus.game_over},       {31'b0, m_over});
      // Inputs as they will be sampled on the coming edge.
      case (m_phase)
        M_IDLE, M_OVER: if (bus.go) begin m_next_start = cyc + 1; m_phase = M_START; end
        M_ISSUE: begin m_stale = bus.chk_ready; m_phase = M_WAIT; end
        M_WAIT: begin
          if (bus.chk_halfway) m_show_off = 1;
          if (bus.chk_ready && !m_stale) begin
            m_pulse_at = cyc + 1; m_verdict = bus.chk_correct; m_phase = M_BUSY;
          end else if (!bus.chk_ready) begin
            m_stale = 0;
          end
        end
        default: ;
      endcase
    end
  end

  // ---------------- driver tasks ----------------
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic press_go();
    bus.go = 1'b1;
    step();
    bus.go = 1'b0;
  endtask

  task automatic wait_start();
    int n = 0;
    while (bus.chk_start !== 1'b1 && n < 60) begin
      step();
      n++;
    end
    if (n >= 60) chk("start_timeout", {31'b0, bus.chk_start}, 32'd1);
  endtask

  // Reference check_move: halfway after lat cycles, verdict one cycle later.
  task automatic play(input logic ok, input int lat);
    wait_start();
    repeat (lat) step();
    bus.chk_halfway = 1'b1;
    step();
    bus.chk_halfway = 1'b0;
    bus.chk_ready   = 1'b1;
    bus.chk_correct = ok;
    step();
    bus.chk_ready   = 1'b0;
    bus.chk_correct = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    repeat (2) step();
    rst = 1'b0;
    step();
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  // ---------------- stimulus ----------------
  initial begin
    logic any_start;
    bus.go = 1'b0; bus.chk_ready = 1'b0; bus.chk_correct = 1'b0; bus.chk_halfway = 1'b0;
    do_reset();

    // 1: go latency, then reset in the middle of WAIT
    press_go();
    chk("go_start_lat", {31'b0, bus.chk_start}, 32'd1);
    chk("go_freq",      {3'b0, bus.play_freq},  32'd100);
    chk("go_lives",     {30'b0, bus.lives},     32'd3);
    play(1'b1, 1);
    chk("r1_score", {22'b0, bus.score},     32'd1);
    chk("r1_freq",  {3'b0, bus.play_freq},  32'd90);
    wait_start();
    step();
    rst = 1'b1;
    #1;
    chk("rst_start", {31'b0, bus.chk_start}, 32'd0);
    chk("rst_move",  {19'b0, bus.move},      32'd0);
    chk("rst_freq",  {3'b0, bus.play_freq},  32'd100);
    chk("rst_score", {22'b0, bus.score},     32'd0);
    chk("rst_busy",  {31'b0, bus.busy},      32'd0);
    chk("rst_show",  {31'b0, bus.move_show}, 32'd0);
    step();
    rst = 1'b0;
    step();

    // 2: three correct moves
    press_go();
    for (int i = 0; i < 3; i++) begin
      play(1'b1, 1 + i);
      chk("t2_freq", {3'b0, bus.play_freq}, 32'(90 - 10 * i));
    end
    chk("t2_score", {22'b0, bus.score}, 32'd3);
    chk("t2_lives", {30'b0, bus.lives}, 32'd3);

    // 3: ten correct moves from a fresh game -> floor at 50
    do_reset();
    press_go();
    for (int i = 0; i < 10; i++) play(1'b1, 2);
    chk("t3_freq",  {3'b0, bus.play_freq}, 32'd50);
    chk("t3_score", {22'b0, bus.score},    32'd10);

    // 4: three wrong moves -> game over, then restart
    for (int i = 0; i < 3; i++) begin
      play(1'b0, 1);
      chk("t4_lives", {30'b0, bus.lives}, 32'(2 - i));
    end
    step();
    chk("t4_over", {31'b0, bus.game_over}, 32'd1);
    any_start = 1'b0;
    repeat (20) begin
      step();
      any_start = any_start | bus.chk_start;
    end
    chk("t4_no_start", {31'b0, any_start}, 32'd0);
    press_go();
    chk("t4_new_score", {22'b0, bus.score},     32'd0);
    chk("t4_new_lives", {30'b0, bus.lives},     32'd3);
    chk("t4_new_freq",  {3'b0, bus.play_freq},  32'd100);
    chk("t4_new_over",  {31'b0, bus.game_over}, 32'd0);

    // 5: stale ready through ISSUE, go pulses in WAIT ignored
    bus.chk_ready = 1'b1;
    step();
    bus.go = 1'b1;
    step();
    bus.go = 1'b0;
    step();
    chk("t5_no_pass", {31'b0, bus.round_pass}, 32'd0);
    chk("t5_no_fail", {31'b0, bus.round_fail}, 32'd0);
    chk("t5_busy",    {31'b0, bus.busy},       32'd1);
    bus.chk_ready = 1'b0;
    step();
    bus.chk_ready   = 1'b1;
    bus.chk_correct = 1'b1;
    step();
    bus.chk_ready   = 1'b0;
    bus.chk_correct = 1'b0;
    chk("t5_pass",  {31'b0, bus.round_pass}, 32'd1);
    chk("t5_score", {22'b0, bus.score},      32'd1);

    // 6: long game -> score saturates, all moves seen
    do_reset();
    seen = '0;
    press_go();
    for (int i = 0; i < 1030; i++) play((i != 500) && (i != 700), $urandom_range(3, 1));
    chk("t6_score", {22'b0, bus.score},    32'd1023);
    chk("t6_lives", {30'b0, bus.lives},    32'd1);
    chk("t6_freq",  {3'b0, bus.play_freq}, 32'd50);
    chk("t6_seen",  {19'b0, seen},         32'h1FFF);

    repeat (5) step();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
